adc_ring_writer: RTL and testbench

//  Sits between adc_data_capture and the data RAM's ADC write-only port. Paces sampling of
//  the EMG and ECG XADC channels, boxcar-averages 2^AVG_LOG2 samples per channel, and writes
//  the averaged values into two circular buffers in RAM. It also reports the buffer write

---
 rtl/adc_ring_writer.sv | 82 ++++++++
 tb/tb_adc_ring_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_ring_writer.sv
// adc_ring_writer: paces EMG/ECG sampling, boxcar-averages them and writes the averages into two RAM ring buffers (in: clock, reset, enable, emg_in, ecg_in; out: adc_wEn/adc_addr/adc_dataIn RAM write port, wr_ptr, frame_done, busy)
module adc_ring_writer #(
  parameter int SAMPLE_INTERVAL = 125000,
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH = 640,
  parameter logic [11:0] EMG_BASE = 12'h400,
  parameter logic [11:0] ECG_BASE = 12'h800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] emg_in,
  input  logic [31:0] ecg_in,
  output logic        adc_wEn,
  output logic [11:0] adc_addr,
  output logic [31:0] adc_dataIn,
  output logic [9:0]  wr_ptr,
  output logic        frame_done,
  output logic        busy
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int TW = $clog2(SAMPLE_INTERVAL);
  localparam int CW = AVG_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, WR_EMG, WR_ECG} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] acc_cnt;
  logic [AW-1:0] emg_acc, ecg_acc, emg_sum, ecg_sum;
  logic tick, last, wrap, wen_n, fd_n;
  logic [11:0] addr_n, data_n;
  logic [9:0] ptr_n;
  logic unused;
  assign unused = ^{emg_in[31:16], emg_in[3:0], ecg_in[31:16], ecg_in[3:0]};
  assign tick = (tick_cnt == TW'(SAMPLE_INTERVAL - 1)) && enable;
  assign last = acc_cnt == CW'((1 << AVG_LOG2) - 1);
  assign emg_sum = emg_acc + AW'(emg_in[15:4]);
  assign ecg_sum = ecg_acc + AW'(ecg_in[15:4]);
  always_comb
    state_n = state == IDLE ? (tick && last ? WR_EMG : IDLE) : state == WR_EMG ? WR_ECG : IDLE;
  // Output values are computed for the coming state so they appear registered in that state;
  // the EMG average must include the final tick's sample, hence emg_sum.
  always_comb begin
    wen_n = state_n != IDLE;
    addr_n = state_n == WR_EMG ? EMG_BASE + 12'(wr_ptr) : state_n == WR_ECG ? ECG_BASE + 12'(wr_ptr) : 12'h0;
    data_n = state_n == WR_EMG ? 12'(emg_sum >> AVG_LOG2) : state_n == WR_ECG ? 12'(ecg_acc >> AVG_LOG2) : 12'h0;
    wrap = state == WR_ECG && wr_ptr == 10'(DEPTH - 1);
    ptr_n = state == WR_ECG ? (wrap ? 10'd0 : wr_ptr + 10'd1) : wr_ptr;
    fd_n = wrap;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      acc_cnt <= '0;
      emg_acc <= '0;
      ecg_acc <= '0;
      adc_wEn <= 1'b0;
      adc_addr <= '0;
      adc_dataIn <= '0;
      wr_ptr <= '0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      adc_wEn <= wen_n;
      busy <= wen_n;
      adc_addr <= addr_n;
      adc_dataIn <= {20'b0, data_n};
      wr_ptr <= ptr_n;
      frame_done <= fd_n;
      tick_cnt <= (!enable || tick) ? '0 : tick_cnt + 1'b1;
      if (state == WR_ECG || (state == IDLE && !enable)) begin
        acc_cnt <= '0;
        emg_acc <= '0;
        ecg_acc <= '0;
      end else if (tick) begin
        emg_acc <= emg_sum;
        ecg_acc <= ecg_sum;
        acc_cnt <= last ? acc_cnt : acc_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_adc_ring_writer.sv
// tb_adc_ring_writer: self-checking bench for adc_ring_writer with SAMPLE_INTERVAL=8, AVG_LOG2=1, DEPTH=4
module tb_adc_ring_writer;
  localparam int SI = 8;
  localparam int DEPTH = 4;
  localparam int N = 160;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [31:0] emg_in = '0, ecg_in = '0;
  logic adc_wEn, frame_done, busy;
  logic [11:0] adc_addr;
  logic [31:0] adc_dataIn;
  logic [9:0] wr_ptr;
  int checks = 0, errors = 0;

  adc_ring_writer #(.SAMPLE_INTERVAL(SI), .AVG_LOG2(1), .DEPTH(DEPTH),
                    .EMG_BASE(12'h400), .ECG_BASE(12'h800)) dut (
    .clock(clock), .reset(reset), .enable(enable), .emg_in(emg_in), .ecg_in(ecg_in),
    .adc_wEn(adc_wEn), .adc_addr(adc_addr), .adc_dataIn(adc_dataIn),
    .wr_ptr(wr_ptr), .frame_done(frame_done), .busy(busy));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] e1, e2, c1, c2;
    logic [31:0] exp_emg, exp_ecg;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic exp_wen[N+3], exp_fd[N+3];
  logic [11:0] exp_addr[N+3], exp_data[N+3];
  logic [9:0] exp_ptr[N+3];

  initial begin
    int wen_seen, fd_seen, ptr;
    logic [11:0] addrs[$];
    logic [11:0] es[$], cs[$];
    logic [11:0] e, c;
    vecs[0] = '{32'h1230, 32'h1230, 32'h4560, 32'h4560, 32'h123, 32'h456};
    vecs[1] = '{32'h1010, 32'h1020, 32'h2000, 32'h2010, 32'h101, 32'h200};
    vecs[2] = '{32'hFFFF, 32'hFFF0, 32'h0000, 32'hFFF0, 32'hFFF, 32'h7FF};
    vecs[3] = '{32'hABCD1235, 32'h0000000F, 32'h00000070, 32'h0000009F, 32'h091, 32'h008};

    #1;
    chk("reset_wen", {31'b0, adc_wEn}, 0);
    chk("reset_addr", {20'b0, adc_addr}, 0);
    chk("reset_data", adc_dataIn, 0);
    chk("reset_ptr", {22'b0, wr_ptr}, 0);
    chk("reset_fd", {31'b0, frame_done}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    do_reset();

    // Vectors: the first write occupies the 17th enabled cycle (after 16 edges).
    for (int v = 0; v < 4; v++) begin
      do_reset();
      enable = 1'b1;
      emg_in = vecs[v].e1;
      ecg_in = vecs[v].c1;
      wen_seen = 0;
      for (int k = 1; k <= 15; k++) begin
        if (k == SI + 1) begin
          emg_in = vecs[v].e2;
          ecg_in = vecs[v].c2;
        end
        step();
        wen_seen += int'(adc_wEn);
      end
      chk($sformatf("v%0d_no_early_wen", v), wen_seen, 0);
      step();
      chk($sformatf("v%0d_emg_wen", v), {31'b0, adc_wEn}, 1);
      chk($sformatf("v%0d_emg_busy", v), {31'b0, busy}, 1);
      chk($sformatf("v%0d_emg_addr", v), {20'b0, adc_addr}, 32'h400);
      chk($sformatf("v%0d_emg_data", v), adc_dataIn, vecs[v].exp_emg);
      step();
      chk($sformatf("v%0d_ecg_wen", v), {31'b0, adc_wEn}, 1);
      chk($sformatf("v%0d_ecg_addr", v), {20'b0, adc_addr}, 32'h800);
      chk($sformatf("v%0d_ecg_data", v), adc_dataIn, vecs[v].exp_ecg);
      step();
      chk($sformatf("v%0d_after_wen", v), {31'b0, adc_wEn}, 0);
      chk($sformatf("v%0d_ptr", v), {22'b0, wr_ptr}, 1);
    end

    // Four pairs: ring addresses and exactly one wrap pulse.
    do_reset();
    enable = 1'b1;
    emg_in = 32'h5550;
    ecg_in = 32'h6660;
    fd_seen = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (adc_wEn) addrs.push_back(adc_addr);
      fd_seen += int'(frame_done);
    end
    chk("ring_writes", addrs.size(), 8);
    for (int i = 0; i < 8 && i < addrs.size(); i++)
      chk($sformatf("ring_addr%0d", i), {20'b0, addrs[i]},
          (i % 2 == 0 ? 32'h400 : 32'h800) + 32'(i / 2));
    chk("ring_fd_count", fd_seen, 1);
    chk("ring_ptr_wrap", {22'b0, wr_ptr}, 0);

    // Enable gap after one pending tick: the pre-drop sample must be discarded.
    do_reset();
    enable = 1'b1;
    emg_in = 32'h7770;
    ecg_in = 32'h7770;
    for (int k = 1; k <= 3 * SI; k++) step();
    enable = 1'b0;
    emg_in = 32'h1110;
    ecg_in = 32'h2220;
    wen_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      wen_seen += int'(adc_wEn);
    end
    chk("gap_no_wen", wen_seen, 0);
    chk("gap_ptr_kept", {22'b0, wr_ptr}, 1);
    enable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      wen_seen += int'(adc_wEn);
    end
    chk("reen_no_early_wen", wen_seen, 0);
    step();
    chk("reen_wen", {31'b0, adc_wEn}, 1);
    chk("reen_emg_addr", {20'b0, adc_addr}, 32'h401);
    chk("reen_emg_data", adc_dataIn, 32'h111);
    step();
    chk("reen_ecg_data", adc_dataIn, 32'h222);
    step();
    chk("reen_ptr", {22'b0, wr_ptr}, 2);

    // Reset asserted while the EMG write is on the port.
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 2 * SI; k++) step();
    chk("pre_rst_wen", {31'b0, adc_wEn}, 1);
    reset = 1'b1;
    #1;
    chk("rst_wen", {31'b0, adc_wEn}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ptr", {22'b0, wr_ptr}, 0);
    chk("rst_fd", {31'b0, frame_done}, 0);
    step();
    reset = 1'b0;
    wen_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      wen_seen += int'(adc_wEn);
    end
    chk("rst_no_ecg", wen_seen, 0);

    // Random samples against a schedule model: every SI-th cycle is a tick, every
    // second tick produces an EMG/ECG write pair and advances the ring pointer.
    do_reset();
    for (int i = 0; i < N + 3; i++) begin
      exp_wen[i] = 1'b0;
      exp_fd[i] = 1'b0;
      exp_addr[i] = '0;
      exp_data[i] = '0;
      exp_ptr[i] = '0;
    end
    ptr = 0;
    enable = 1'b1;
    for (int k = 1; k <= N; k++) begin
      emg_in = $urandom;
      ecg_in = $urandom;
      if (k % SI == 0) begin
        es.push_back(emg_in[15:4]);
        cs.push_back(ecg_in[15:4]);
        if (es.size() == 2) begin
          e = 12'((int'(es[0]) + int'(es[1])) / 2);
          c = 12'((int'(cs[0]) + int'(cs[1])) / 2);
          es.delete();
          cs.delete();
          exp_wen[k] = 1'b1;
          exp_addr[k] = 12'h400 + 12'(ptr);
          exp_data[k] = e;
          exp_wen[k+1] = 1'b1;
          exp_addr[k+1] = 12'h800 + 12'(ptr);
          exp_data[k+1] = c;
          exp_fd[k+2] = ptr == DEPTH - 1;
          ptr = (ptr + 1) % DEPTH;
          for (int j = k + 2; j < N + 3; j++) exp_ptr[j] = 10'(ptr);
        end
      end
      step();
      chk($sformatf("rnd%0d_wen", k), {31'b0, adc_wEn}, {31'b0, exp_wen[k]});
      chk($sformatf("rnd%0d_busy", k), {31'b0, busy}, {31'b0, exp_wen[k]});
      chk($sformatf("rnd%0d_fd", k), {31'b0, frame_done}, {31'b0, exp_fd[k]});
      chk($sformatf("rnd%0d_ptr", k), {22'b0, wr_ptr}, {22'b0, exp_ptr[k]});
      if (exp_wen[k]) begin
        chk($sformatf("rnd%0d_addr", k), {20'b0, adc_addr}, {20'b0, exp_addr[k]});
        chk($sformatf("rnd%0d_data", k), adc_dataIn, {20'b0, exp_data[k]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
